// File: rtl/io_pkg.sv
// Shared types and defaults for the IO module row decoder.
// Holds the controller state enum and the pos-width helper.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    OUT
  } state_t;

  localparam int SECTION_SIZE = 4;
  localparam int ROW_SIZE     = 16;

  // Wide enough for every run in a word at max length, so pos never wraps.
  function automatic int posWidth(int ss, int rs);
    return $clog2((rs / ss) * ((1 << ss) - 1) + 1);
  endfunction

  localparam int POS_W = posWidth(SECTION_SIZE, ROW_SIZE);

endpackage

// File: rtl/rle_row_decode_ctrl_if.sv
// Compressed-word input stream and decoded-row output stream.
// slave = decoder side, master = producer/consumer side.
interface rle_row_decode_ctrl_if
  import io_pkg::*;
#(
  parameter int rowSize = ROW_SIZE
) ();

  logic [rowSize-1:0] inData;
  logic               inValid;
  logic               inReady;
  logic [rowSize-1:0] outData;
  logic               outValid;
  logic               outReady;

  modport slave (
    input  inData,
    input  inValid,
    output inReady,
    output outData,
    output outValid,
    input  outReady
  );

  modport master (
    output inData,
    output inValid,
    input  inReady,
    input  outData,
    input  outValid,
    output outReady
  );

endinterface

// File: rtl/rle_row_decode_ctrl_run_mask.sv
// OR-mask for one run of the current digit starting at pos.
// Bits at or beyond rowSize fall off the end of the row.
module rle_run_mask
  import io_pkg::*;
#(
  parameter int sectionSize = SECTION_SIZE,
  parameter int rowSize     = ROW_SIZE,
  parameter int posW        = POS_W
) (
  input  logic [posW-1:0]        pos,
  input  logic [sectionSize-1:0] runLen,
  input  logic                   digit,
  output logic [rowSize-1:0]     mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < rowSize; i++) begin
      mask[i] = digit
        && (i >= int'(pos))
        && (i < int'(pos) + int'(runLen));
    end
  end

endmodule

// File: rtl/rle_row_decode_ctrl.sv
// Run-length row decoder and frame controller, one section per clock.
// Define RLE_OVF_CHECK_EN to add the sticky run-overflow flag err.
module rle_row_decode_ctrl
  import io_pkg::*;
#(
  parameter int sectionSize = SECTION_SIZE,
  parameter int rowSize     = ROW_SIZE,
  parameter int rowCntW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [rowCntW-1:0] cfgRows,
  rle_row_decode_ctrl_if.slave bus,
  output logic               busy,
  output logic               done
`ifdef RLE_OVF_CHECK_EN
  ,
  output logic               err
`endif
);

  localparam int posW = posWidth(sectionSize, rowSize);

  state_t state, stateNxt;

  logic [rowSize-1:0]     sreg;
  logic [rowSize-1:0]     row;
  logic [rowSize-1:0]     runMask;
  logic [posW-1:0]        pos;
  logic                   digit;
  logic [rowCntW-1:0]     rowCnt;
  logic [sectionSize-1:0] runLen;
  logic                   sregZero;

  assign runLen   = sreg[sectionSize-1:0];
  assign sregZero = (sreg == '0);

  assign bus.inReady  = (state == FETCH);
  assign bus.outValid = (state == OUT);
  assign bus.outData  = row;

  rle_run_mask #(
    .sectionSize(sectionSize),
    .rowSize    (rowSize),
    .posW       (posW)
  ) uMask (
    .pos   (pos),
    .runLen(runLen),
    .digit (digit),
    .mask  (runMask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:
        if (start && cfgRows != '0)
          stateNxt = FETCH;
      FETCH:
        if (bus.inValid)
          stateNxt = DECODE;
      DECODE:
        if (sregZero)
          stateNxt = OUT;
      OUT:
        if (bus.outReady)
          stateNxt = (rowCnt == rowCntW'(1)) ? IDLE : FETCH;
      default:
        stateNxt = IDLE;
    endcase
  end

`ifdef RLE_OVF_CHECK_EN
  logic [posW:0] runEnd;
  logic          runOvf;

  assign runEnd = {1'b0, pos} + (posW + 1)'(runLen);
  assign runOvf = runEnd > (posW + 1)'(rowSize);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (state == IDLE && start)
      err <= 1'b0;
    else if (state == DECODE && !sregZero && runOvf)
      err <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      row    <= '0;
      pos    <= '0;
      digit  <= 1'b0;
      rowCnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE:
          if (start) begin
            rowCnt <= cfgRows;
            if (cfgRows == '0) done <= 1'b1;
            else               busy <= 1'b1;
          end
        FETCH:
          if (bus.inValid) begin
            sreg  <= bus.inData;
            row   <= '0;
            pos   <= '0;
            digit <= 1'b0;
          end
        DECODE:
          if (!sregZero) begin
            row   <= row | runMask;
            pos   <= pos + posW'(runLen);
            sreg  <= sreg >> sectionSize;
            digit <= ~digit;
          end
        OUT:
          if (bus.outReady) begin
            rowCnt <= rowCnt - rowCntW'(1);
            if (rowCnt == rowCntW'(1)) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
        default: ;
      endcase
    end
  end

endmodule
